fifo_to_axis: RTL and testbench

//  Read side of the SRAM FIFO path: pops {tdata,tlast} words from the FIFO read port and drives an AXI4-Stream master.

---
 rtl/nf10_sram_fifo_pkg.sv | 18 +
 rtl/fifo_to_axis_out_buf.sv | 62 ++++++
 rtl/fifo_to_axis.sv | 116 +++++++++++
 tb/tb_fifo_to_axis.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nf10_sram_fifo_pkg.sv
// Shared definitions for the SRAM FIFO read path: FIFO word width and tuser port-field offsets.
package nf10_sram_fifo_pkg;

    localparam int SRC_PORT_LSB = 16;
    localparam int DST_PORT_LSB = 24;

    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_FULL  = 2'd2
    } occ_e;

    // One FIFO word is {tdata, tlast}.
    function automatic int fifo_word_width(input int tdata_bytes);
        return 8 * tdata_bytes + 1;
    endfunction

endpackage

// File: rtl/fifo_to_axis_out_buf.sv
// axis_out_buf: 2-entry skid buffer between the FIFO read data and the AXI-S output.
// Entry 0 is always the head; upstream guarantees no push while full without a pop.
module axis_out_buf
    import nf10_sram_fifo_pkg::*;
#(
    parameter int W = 257
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push_i,
    input  logic [W-1:0] push_data_i,
    input  logic         pop_i,
    output occ_e         occ_o,
    output logic [W-1:0] head_o
);

    logic [W-1:0] ent0_q, ent0_d;
    logic [W-1:0] ent1_q, ent1_d;
    occ_e         occ_q, occ_d;

    always_comb begin
        ent0_d = ent0_q;
        ent1_d = ent1_q;
        occ_d  = occ_q;
        if (push_i && pop_i) begin
            if (occ_q == OCC_FULL) begin
                ent0_d = ent1_q;
                ent1_d = push_data_i;
            end else begin
                ent0_d = push_data_i;
                occ_d  = OCC_ONE;
            end
        end else if (push_i) begin
            if (occ_q == OCC_EMPTY) begin
                ent0_d = push_data_i;
                occ_d  = OCC_ONE;
            end else if (occ_q == OCC_ONE) begin
                ent1_d = push_data_i;
                occ_d  = OCC_FULL;
            end
        end else if (pop_i) begin
            ent0_d = ent1_q;
            occ_d  = (occ_q == OCC_FULL) ? OCC_ONE : OCC_EMPTY;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ent0_q <= '0;
            ent1_q <= '0;
            occ_q  <= OCC_EMPTY;
        end else begin
            ent0_q <= ent0_d;
            ent1_q <= ent1_d;
            occ_q  <= occ_d;
        end
    end

    assign occ_o  = occ_q;
    assign head_o = ent0_q;

endmodule

// File: rtl/fifo_to_axis.sv
// fifo_to_axis: pops {tdata,tlast} words from the SRAM FIFO read port and drives an AXI4-Stream master.
// Optional packet counter enabled by defining FIFO_TO_AXIS_PKT_CNT_EN.
module fifo_to_axis
    import nf10_sram_fifo_pkg::*;
#(
    parameter int         TDATA_WIDTH = 32,
    parameter int         TUSER_WIDTH = 128,
    parameter int         TID_WIDTH   = 4,
    parameter int         TDEST_WIDTH = 4,
    parameter logic [7:0] DST_PORT    = 8'h01,
    parameter logic [7:0] SRC_PORT    = 8'h00
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       cal_done,
    input  logic                       rempty,
    output logic                       rinc,
    input  logic                       din_valid,
    input  logic [8*TDATA_WIDTH:0]     din,
    output logic                       tvalid,
    input  logic                       tready,
    output logic [8*TDATA_WIDTH-1:0]   tdata,
    output logic [TDATA_WIDTH-1:0]     tstrb,
    output logic [TDATA_WIDTH-1:0]     tkeep,
    output logic                       tlast,
    output logic [TID_WIDTH-1:0]       tid,
    output logic [TDEST_WIDTH-1:0]     tdest,
    output logic [TUSER_WIDTH-1:0]     tuser,
    output logic                       output_inc,
    output logic [31:0]                output_fifo_cnt,
    output logic [31:0]                output_pkt_cnt,
    output logic                       rd_err
);

    localparam int WW = fifo_word_width(TDATA_WIDTH);
    localparam logic [TUSER_WIDTH-1:0] TUSER_C =
        (TUSER_WIDTH'(DST_PORT) << DST_PORT_LSB) | (TUSER_WIDTH'(SRC_PORT) << SRC_PORT_LSB);

    logic [WW-1:0] head;
    occ_e          occ;
    logic          push;
    logic          pop;
    logic [2:0]    lvl;
    logic          infl_q, infl_d;
    logic          rd_err_q, rd_err_d;
    logic [31:0]   fifo_cnt_q;
    logic [31:0]   fifo_cnt_d;

    axis_out_buf #(
        .W (WW)
    ) u_buf (
        .clk         (clk),
        .reset       (reset),
        .push_i      (push),
        .push_data_i (din),
        .pop_i       (pop),
        .occ_o       (occ),
        .head_o      (head)
    );

    assign tvalid = (occ != OCC_EMPTY);
    assign pop    = tvalid & tready & ~reset;
    // A word returning while nothing is outstanding (e.g. requested before reset) is dropped.
    assign push   = din_valid & infl_q & ~reset;

    // Buffered plus in-flight words must never exceed the two buffer slots.
    assign lvl  = {1'b0, occ} + {2'b00, infl_q};
    assign rinc = ~reset & cal_done & ~rempty & ((lvl < 3'd2) | ((lvl == 3'd2) & pop));

    assign infl_d     = rinc;
    assign rd_err_d   = rd_err_q | (din_valid & ~infl_q);
    assign fifo_cnt_d = fifo_cnt_q + {31'b0, pop};

    always_ff @(posedge clk) begin
        if (reset) begin
            infl_q     <= 1'b0;
            rd_err_q   <= 1'b0;
            fifo_cnt_q <= '0;
        end else begin
            infl_q     <= infl_d;
            rd_err_q   <= rd_err_d;
            fifo_cnt_q <= fifo_cnt_d;
        end
    end

`ifdef FIFO_TO_AXIS_PKT_CNT_EN
    logic [31:0] pkt_cnt_q;
    logic [31:0] pkt_cnt_d;

    assign pkt_cnt_d = pkt_cnt_q + {31'b0, pop & head[0]};

    always_ff @(posedge clk) begin
        if (reset) begin
            pkt_cnt_q <= '0;
        end else begin
            pkt_cnt_q <= pkt_cnt_d;
        end
    end

    assign output_pkt_cnt = pkt_cnt_q;
`else
    assign output_pkt_cnt = 32'b0;
`endif

    assign tdata           = head[WW-1:1];
    assign tlast           = head[0];
    assign tstrb           = '1;
    assign tkeep           = '1;
    assign tid             = '0;
    assign tdest           = '0;
    assign tuser           = TUSER_C;
    assign output_inc      = pop;
    assign output_fifo_cnt = fifo_cnt_q;
    assign rd_err          = rd_err_q;

endmodule

// File: tb/tb_fifo_to_axis.sv
// Scoreboard bench for fifo_to_axis: a FIFO source model feeds words, a negedge monitor checks every beat.
module tb_fifo_to_axis;
    localparam int DW  = 256;
    localparam int WW  = 257;
    localparam int TUW = 128;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            cal_done = 1'b0;
    logic            rempty = 1'b1;
    logic            rinc;
    logic            din_valid = 1'b0;
    logic [WW-1:0]   din = '0;
    logic            tvalid;
    logic            tready = 1'b0;
    logic [DW-1:0]   tdata;
    logic [31:0]     tstrb, tkeep;
    logic            tlast;
    logic [3:0]      tid, tdest;
    logic [TUW-1:0]  tuser;
    logic            output_inc;
    logic [31:0]     output_fifo_cnt, output_pkt_cnt;
    logic            rd_err;

    fifo_to_axis dut (
        .clk(clk), .reset(reset), .cal_done(cal_done), .rempty(rempty), .rinc(rinc),
        .din_valid(din_valid), .din(din), .tvalid(tvalid), .tready(tready), .tdata(tdata),
        .tstrb(tstrb), .tkeep(tkeep), .tlast(tlast), .tid(tid), .tdest(tdest), .tuser(tuser),
        .output_inc(output_inc), .output_fifo_cnt(output_fifo_cnt),
        .output_pkt_cnt(output_pkt_cnt), .rd_err(rd_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [WW-1:0] src_q[$];
    logic [WW-1:0] exp_q[$];
    bit  hold_empty = 1'b0;
    bit  spur_req = 1'b0;
    bit  rinc_s = 1'b0;
    bit  prev_stall = 1'b0;
    logic [WW-1:0] prev_word = '0;
    int  words_issued = 0;
    int  pkts_issued = 0;

    task automatic chk(input string name, input logic [WW-1:0] got, input logic [WW-1:0] expv);
        checks++;
        if (got !== expv) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", name, got, expv);
        end
    endtask

    function automatic logic [WW-1:0] mk_word(input int tag, input int idx, input bit last);
        logic [DW-1:0] d;
        for (int k = 0; k < 8; k++) d[k*32 +: 32] = 32'(tag * 65536 + idx * 16 + k);
        return {d, last};
    endfunction

    task automatic load_pkt(input int tag, input int len);
        logic [WW-1:0] w;
        for (int i = 0; i < len; i++) begin
            w = mk_word(tag, i, i == len - 1);
            src_q.push_back(w);
            exp_q.push_back(w);
        end
        words_issued += len;
        pkts_issued++;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_drain(input int budget, input bit rand_ready);
        int i;
        for (i = 0; i < budget; i++) begin
            step();
            if (rand_ready) tready = 1'($urandom_range(0, 1));
            if (src_q.size() == 0 && exp_q.size() == 0) break;
        end
        checks++;
        if (i >= budget) begin
            errors++;
            $display("FAIL drain_timeout got=%0d left expected=0", exp_q.size());
        end
        tready = 1'b1;
    endtask

    // FIFO source: a word requested by rinc appears with din_valid one cycle later.
    always @(posedge clk) begin
        #2;
        if (rinc_s && src_q.size() > 0) begin
            din_valid = 1'b1;
            din = src_q.pop_front();
        end else if (spur_req) begin
            din_valid = 1'b1;
            din = '1;
            spur_req = 1'b0;
        end else begin
            din_valid = 1'b0;
        end
        rempty = (src_q.size() == 0) || hold_empty;
    end

    // Monitor: pops the scoreboard on every accepted beat.
    always @(negedge clk) begin
        logic [WW-1:0] e;
        rinc_s = rinc;
        if (!reset) begin
            chk("output_inc", output_inc, tvalid && tready);
            if (prev_stall) begin
                chk("stall_tvalid", tvalid, 1'b1);
                chk("stall_word", {tdata, tlast}, prev_word);
            end
            if (tvalid && tready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_beat got=%0h expected=none", {tdata, tlast});
                end else begin
                    e = exp_q.pop_front();
                    chk("beat_word", {tdata, tlast}, e);
                end
                chk("tuser", tuser, 128'h0100_0000);
                chk("tkeep_tstrb", {tkeep, tstrb}, {32'hFFFF_FFFF, 32'hFFFF_FFFF});
                chk("tid_tdest", {tid, tdest}, 8'h00);
            end
            prev_stall = tvalid && !tready;
            prev_word  = {tdata, tlast};
        end else begin
            prev_stall = 1'b0;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit [7:0] rinc_h, tv_h, tl_h;
        int rc, first;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_tvalid", tvalid, 1'b0);
        chk("rst_rinc", rinc, 1'b0);
        chk("rst_word", {tdata, tlast}, '0);
        chk("rst_cnt", output_fifo_cnt, 32'd0);
        chk("rst_pkt_cnt", output_pkt_cnt, 32'd0);
        chk("rst_rd_err", rd_err, 1'b0);
        chk("rst_output_inc", output_inc, 1'b0);
        step();
        reset = 1'b0;
        cal_done = 1'b1;
        tready = 1'b1;
        repeat (2) step();

        // 1: single 4-beat packet, tready high
        load_pkt(1, 4);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            rinc_h[i] = rinc;
            tv_h[i]   = tvalid;
            tl_h[i]   = tlast & tvalid;
        end
        chk("t1_rinc_timeline", rinc_h, 8'b0000_1111);
        chk("t1_tvalid_timeline", tv_h, 8'b0011_1100);
        chk("t1_tlast_timeline", tl_h, 8'b0010_0000);
        wait_drain(50, 1'b0);
        chk("t1_cnt", output_fifo_cnt, 32'd4);

        // 2: backpressure with 8 words queued
        step();
        tready = 1'b0;
        load_pkt(2, 8);
        rc = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (rinc) rc++;
        end
        chk("t2_rinc_under_stall", rc, 2);
        chk("t2_cnt_stalled", output_fifo_cnt, 32'd4);
        step();
        tready = 1'b1;
        wait_drain(100, 1'b0);
        chk("t2_cnt", output_fifo_cnt, 32'd12);

        // 3: cal_done low blocks reads
        step();
        cal_done = 1'b0;
        load_pkt(3, 3);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t3_rinc_blocked", rinc, 1'b0);
            chk("t3_tvalid_blocked", tvalid, 1'b0);
        end
        step();
        cal_done = 1'b1;
        first = -1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (tvalid && first < 0) first = i;
        end
        chk("t3_first_tvalid_delay", first, 2);
        wait_drain(50, 1'b0);
        chk("t3_cnt", output_fifo_cnt, 32'd15);

        // 4: random tready / rempty / cal_done over many packets
        for (int p = 0; p < 40; p++) begin
            int len;
            len = $urandom_range(1, 16);
            load_pkt(100 + p, len);
            repeat ($urandom_range(1, len)) begin
                step();
                tready     = 1'($urandom_range(0, 1));
                hold_empty = ($urandom_range(0, 3) == 0);
                cal_done   = ($urandom_range(0, 7) != 0);
            end
        end
        step();
        hold_empty = 1'b0;
        cal_done = 1'b1;
        wait_drain(3000, 1'b1);
        repeat (3) step();
        chk("t4_cnt", output_fifo_cnt, 32'(words_issued));
`ifdef FIFO_TO_AXIS_PKT_CNT_EN
        chk("t4_pkt_cnt", output_pkt_cnt, 32'(pkts_issued));
`else
        chk("t4_pkt_cnt_tied", output_pkt_cnt, 32'd0);
`endif

        // 5: beat counter wrap
        tready = 1'b0;
        step();
        force dut.fifo_cnt_d = 32'hFFFF_FFFF;
        step();
        release dut.fifo_cnt_d;
        @(negedge clk);
        chk("t5_cnt_preload", output_fifo_cnt, 32'hFFFF_FFFF);
        step();
        tready = 1'b1;
        load_pkt(5, 1);
        wait_drain(50, 1'b0);
        step();
        chk("t5_cnt_wrap", output_fifo_cnt, 32'd0);
`ifdef FIFO_TO_AXIS_PKT_CNT_EN
        chk("t5_pkt_cnt", output_pkt_cnt, 32'(pkts_issued));
`else
        chk("t5_pkt_cnt_tied", output_pkt_cnt, 32'd0);
`endif

        // 6: reset mid-packet with a read in flight
        step();
        tready = 1'b0;
        for (int i = 0; i < 6; i++) src_q.push_back(mk_word(6, i, i == 5));
        rc = 0;
        for (int i = 0; i < 10 && rc < 2; i++) begin
            @(negedge clk);
            if (rinc) rc++;
        end
        chk("t6_two_reads", rc, 2);
        step();
        reset = 1'b1;
        step();
        src_q.delete();
        @(negedge clk);
        chk("t6_rst_tvalid", tvalid, 1'b0);
        chk("t6_rst_word", {tdata, tlast}, '0);
        chk("t6_rst_rinc", rinc, 1'b0);
        chk("t6_rst_cnt", output_fifo_cnt, 32'd0);
        chk("t6_stale_rd_err", rd_err, 1'b0);
        step();
        reset = 1'b0;
        tready = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("t6_rd_err_quiet", rd_err, 1'b0);
            chk("t6_tvalid_quiet", tvalid, 1'b0);
        end
        step();
        spur_req = 1'b1;
        repeat (2) @(negedge clk);
        chk("t6_spurious_rd_err", rd_err, 1'b1);
        chk("t6_spurious_no_beat", tvalid, 1'b0);
        repeat (2) step();
        chk("t6_rd_err_sticky", rd_err, 1'b1);
        chk("t6_no_leftover_exp", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
